// File: rtl/ceespu_timer.sv
// Ceespu programmable timer: prescaled up-counter with compare match
// and a one-cycle interrupt request pulse, on a single-cycle register bus.
module ceespu_timer #(
    parameter int PRESCALE_W = 16,
    parameter int COUNT_W    = 32
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_sel,
    input  logic               I_we,
    input  logic [2:0]         I_addr,
    input  logic [COUNT_W-1:0] I_wdata,
    output logic [COUNT_W-1:0] O_rdata,
    output logic               O_intr_rq
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_COUNT    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    logic                  en;
    logic                  periodic;
    logic                  irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic [COUNT_W-1:0]    compare;
    logic [COUNT_W-1:0]    count;
    logic                  match_st;

    logic wr;
    logic rd;
    logic wr_ctrl;
    logic wr_count;
    logic tick;
    logic hit;

    assign wr       = I_sel && I_we;
    assign rd       = I_sel && !I_we;
    assign wr_ctrl  = wr && (I_addr == A_CTRL);
    assign wr_count = wr && (I_addr == A_COUNT);
    assign tick     = en && (psc_cnt == prescale);
    // A COUNT write in the tick cycle suppresses the compare entirely.
    assign hit      = tick && !wr_count && (count == compare);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            psc_cnt <= '0;
        end else if (!en || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + 1'b1;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= I_wdata;
        end else if (hit) begin
            if (periodic) count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // One-shot match clears EN even if the CPU writes EN=1 the same cycle.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en       <= I_wdata[0];
                periodic <= I_wdata[1];
                irq_en   <= I_wdata[2];
            end
            if (hit && !periodic) en <= 1'b0;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            prescale <= '0;
            compare  <= '0;
        end else if (wr) begin
            if (I_addr == A_PRESCALE) prescale <= I_wdata[PRESCALE_W-1:0];
            if (I_addr == A_COMPARE)  compare  <= I_wdata;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            match_st  <= 1'b0;
            O_intr_rq <= 1'b0;
        end else begin
            if (wr && (I_addr == A_STATUS) && I_wdata[0]) match_st <= 1'b0;
            if (hit) match_st <= 1'b1;
            O_intr_rq <= hit && irq_en;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_rdata <= '0;
        end else if (rd) begin
            unique case (I_addr)
                A_CTRL:     O_rdata <= COUNT_W'({irq_en, periodic, en});
                A_PRESCALE: O_rdata <= COUNT_W'(prescale);
                A_COMPARE:  O_rdata <= compare;
                A_COUNT:    O_rdata <= count;
                A_STATUS:   O_rdata <= COUNT_W'(match_st);
                default:    O_rdata <= '0;
            endcase
        end
    end

endmodule
